// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared constants for the fetch redirect controller: state encoding and parameter defaults.
package fetch_ctrl_pkg;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_PEND = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_CNT_W    = 32;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: advances, holds or redirects the PC from BTB next-PC/flush and stall inputs,
// buffering a mispredict redirect that lands during a memory stall.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_stall_i,
  input  logic             hazard_stall_i,
  input  logic [31:0]      next_pc_i,
  input  logic             flush_i,
  input  logic             is_branch_3_i,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             btb_stall_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        flush, stall, br_inc, mp_inc;
  logic [31:0] next_pc_aligned;

  assign next_pc_aligned = {next_pc_i[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    flush     = 1'b0;
    stall     = 1'b0;
    br_inc    = 1'b0;
    mp_inc    = 1'b0;
    if (state_q == ST_RUN) begin
      if (flush_i) begin
        br_inc = 1'b1;
        mp_inc = 1'b1;
        if (mem_stall_i) begin
          // Redirect cannot be applied while memory is stalled; park it.
          pend_pc_d = next_pc_aligned;
          stall     = 1'b1;
          state_d   = ST_PEND;
        end else begin
          pc_d  = next_pc_aligned;
          flush = 1'b1;
        end
      end else if (mem_stall_i) begin
        stall = 1'b1;
      end else if (hazard_stall_i) begin
        // EX keeps moving under a load-use stall, so a resolving branch still counts.
        stall  = 1'b1;
        br_inc = is_branch_3_i;
      end else begin
        pc_d   = next_pc_aligned;
        br_inc = is_branch_3_i;
      end
    end else begin
      if (mem_stall_i) begin
        stall = 1'b1;
      end else begin
        pc_d    = pend_pc_q;
        flush   = 1'b1;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (br_inc),
    .cnt_o (branch_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mp_inc),
    .cnt_o (mispred_cnt_o)
  );

  assign pc_o        = pc_q;
  assign flush_o     = flush;
  assign stall_o     = stall;
  assign pend_o      = (state_q == ST_PEND);
  assign btb_stall_o = mem_stall_i | (state_q == ST_PEND);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl; narrow counters so saturation is reachable.
module tb_fetch_redirect_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_stall_i = 1'b0;
  logic          hazard_stall_i = 1'b0;
  logic [31:0]   next_pc_i = '0;
  logic          flush_i = 1'b0;
  logic          is_branch_3_i = 1'b0;
  logic [31:0]   pc_o;
  logic          flush_o, stall_o, btb_stall_o, pend_o;
  logic [CW-1:0] branch_cnt_o, mispred_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  fetch_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_stall_i    (mem_stall_i),
    .hazard_stall_i (hazard_stall_i),
    .next_pc_i      (next_pc_i),
    .flush_i        (flush_i),
    .is_branch_3_i  (is_branch_3_i),
    .pc_o           (pc_o),
    .flush_o        (flush_o),
    .stall_o        (stall_o),
    .btb_stall_o    (btb_stall_o),
    .pend_o         (pend_o),
    .branch_cnt_o   (branch_cnt_o),
    .mispred_cnt_o  (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs, check combinational outputs, queue expected next PC, compare after the edge.
  task automatic drive(input logic mem, input logic haz, input logic fl, input logic br,
                       input logic [31:0] npc, input logic e_flush, input logic e_stall,
                       input logic [31:0] e_pc, input string name);
    logic [31:0] exp_pc;
    mem_stall_i = mem; hazard_stall_i = haz; flush_i = fl; is_branch_3_i = br; next_pc_i = npc;
    #1;
    n_checks++;
    if (flush_o !== e_flush) begin
      n_fail++; $display("FAIL %s flush_o got %b want %b", name, flush_o, e_flush);
    end
    n_checks++;
    if (stall_o !== e_stall) begin
      n_fail++; $display("FAIL %s stall_o got %b want %b", name, stall_o, e_stall);
    end
    n_checks++;
    if (btb_stall_o !== (mem | pend_o)) begin
      n_fail++; $display("FAIL %s btb_stall_o got %b want %b", name, btb_stall_o, mem | pend_o);
    end
    exp_q.push_back(e_pc);
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard empty", name);
    end else begin
      exp_pc = exp_q.pop_front();
      if (pc_o !== exp_pc) begin
        n_fail++; $display("FAIL %s pc_o got %h want %h", name, pc_o, exp_pc);
      end
    end
  endtask

  task automatic check_state(input logic e_pend, input logic [CW-1:0] e_br,
                             input logic [CW-1:0] e_mp, input string name);
    n_checks++;
    if (pend_o !== e_pend) begin
      n_fail++; $display("FAIL %s pend_o got %b want %b", name, pend_o, e_pend);
    end
    n_checks++;
    if (branch_cnt_o !== e_br) begin
      n_fail++; $display("FAIL %s branch_cnt got %0d want %0d", name, branch_cnt_o, e_br);
    end
    n_checks++;
    if (mispred_cnt_o !== e_mp) begin
      n_fail++; $display("FAIL %s mispred_cnt got %0d want %0d", name, mispred_cnt_o, e_mp);
    end
  endtask

  task automatic clear_inputs();
    mem_stall_i = 0; hazard_stall_i = 0; flush_i = 0; is_branch_3_i = 0; next_pc_i = '0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (pc_o !== 32'h0) begin
      n_fail++; $display("FAIL reset pc_o got %h want 0", pc_o);
    end
    n_checks++;
    if ({flush_o, stall_o, btb_stall_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset comb got %b want 000", {flush_o, stall_o, btb_stall_o});
    end
    check_state(1'b0, '0, '0, "reset");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h40, 0, 0, 32'h40, "pre_pend_seq");
    drive(1, 0, 1, 1, 32'h80, 0, 1, 32'h40, "enter_pend");
    check_state(1'b1, 4'd1, 4'd1, "enter_pend");
    // Reset asserted mid-PEND, away from any clock edge.
    clear_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if (pc_o !== 32'h0) begin
      n_fail++; $display("FAIL midpend_reset pc_o got %h want 0", pc_o);
    end
    check_state(1'b0, '0, '0, "midpend_reset");
    #2;
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h4, 0, 0, 32'h4, "post_reset_seq");
    check_state(1'b0, '0, '0, "post_reset_seq");
  endtask

  task automatic test_sequential();
    drive(0, 0, 0, 0, 32'h10, 0, 0, 32'h10, "seq_10");
    drive(0, 0, 0, 1, 32'h14, 0, 0, 32'h14, "seq_branch");
    check_state(1'b0, 4'd1, 4'd0, "seq");
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 1, 32'h200, 1, 0, 32'h200, "flush_200");
    check_state(1'b0, 4'd2, 4'd1, "flush");
  endtask

  task automatic test_pend();
    drive(1, 0, 1, 1, 32'h300, 0, 1, 32'h200, "pend_capture");
    check_state(1'b1, 4'd3, 4'd2, "pend_capture");
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 1, 32'h999, 0, 1, 32'h200, "pend_hold");
    end
    check_state(1'b1, 4'd3, 4'd2, "pend_hold");
    drive(0, 1, 1, 1, 32'h999, 1, 0, 32'h300, "pend_release");
    check_state(1'b0, 4'd3, 4'd2, "pend_release");
  endtask

  task automatic test_hazard();
    drive(0, 1, 1, 1, 32'h400, 1, 0, 32'h400, "haz_flush_wins");
    check_state(1'b0, 4'd4, 4'd3, "haz_flush_wins");
    drive(0, 1, 0, 1, 32'h500, 0, 1, 32'h400, "haz_hold");
    check_state(1'b0, 4'd5, 4'd3, "haz_hold");
    drive(1, 1, 0, 1, 32'h600, 0, 1, 32'h400, "mem_stall_nocount");
    check_state(1'b0, 4'd5, 4'd3, "mem_stall_nocount");
    drive(0, 0, 0, 0, 32'h203, 0, 0, 32'h200, "align_203");
  endtask

  task automatic test_saturation();
    logic [31:0] tgt;
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tgt = 32'h1000 + 32'(i * 16);
      drive(0, 0, 1, 1, tgt, 1, 0, tgt, "sat_fill");
    end
    check_state(1'b0, 4'd14, 4'd14, "sat_14");
    drive(0, 0, 1, 1, 32'h2000, 1, 0, 32'h2000, "sat_15");
    check_state(1'b0, 4'd15, 4'd15, "sat_15");
    drive(0, 0, 1, 1, 32'h3000, 1, 0, 32'h3000, "sat_hold");
    check_state(1'b0, 4'd15, 4'd15, "sat_hold");
    drive(0, 0, 0, 1, 32'h3004, 0, 0, 32'h3004, "sat_branch_hold");
    check_state(1'b0, 4'd15, 4'd15, "sat_branch_hold");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_flush();
    test_pend();
    test_hazard();
    test_saturation();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the fetch PC register from the branch-target-buffer's next-PC/flush outputs, memory stalls and load-use hazard stalls.
- Decides each cycle whether the PC advances, holds or redirects, and drives pipeline flush/stall.
- Buffers a misprediction redirect that arrives during a memory stall until the stall releases.
- Also drives the BTB's stall input and keeps saturating branch and mispredict performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_stall_i  in  1  I-cache or D-cache miss in progress.
- hazard_stall_i  in  1  load-use hazard; freeze PC and IF/ID.
- next_pc_i  in  32  BTB branch-PC output: corrected target when flush_i=1, otherwise predicted/sequential PC.
- flush_i  in  1  BTB mispredict (taken or target wrong) for the branch in stage 3.
- is_branch_3_i  in  1  stage-3 instruction is a branch.
- pc_o  out  32  current fetch PC (registered).
- flush_o  out  1  flush IF/ID and ID/EX this cycle (combinational).
- stall_o  out  1  freeze PC and IF/ID this cycle (combinational).
- btb_stall_o  out  1  to BTB memory_stall: mem_stall_i | (state==PEND).
- pend_o  out  1  redirect pending (state==PEND).
- branch_cnt_o  out  CNT_W  resolved branches, saturating.
- mispred_cnt_o  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (async, any time incl. mid-PEND):
  - pc_o=RESET_PC, state=RUN, pend_pc=0, both counters 0.
  - Combinational outputs follow state RUN, so with all inputs 0 they are 0.
- PC loads always force bits [1:0]=2'b00.
- Priority in RUN: flush_i > mem_stall_i > hazard_stall_i > advance.
- RUN, flush_i=1, mem_stall_i=0:
  - pc_o<=next_pc_i; flush_o=1, stall_o=0.
  - mispred_cnt+1, branch_cnt+1. Stay RUN.
  - hazard_stall_i is ignored this cycle.
- RUN, flush_i=1, mem_stall_i=1:
  - pend_pc<=next_pc_i; PC holds; stall_o=1, flush_o=0.
  - mispred_cnt+1, branch_cnt+1 (counted here only). Go PEND.
- RUN, flush_i=0, mem_stall_i=1: PC holds, stall_o=1, no count.
- RUN, flush_i=0, mem_stall_i=0, hazard_stall_i=1:
  - PC holds, stall_o=1, flush_o=0.
  - branch_cnt+1 if is_branch_3_i (EX still advances).
- RUN, all clear: pc_o<=next_pc_i; branch_cnt+1 if is_branch_3_i.
- PEND, mem_stall_i=1:
  - PC holds, stall_o=1.
  - flush_i and is_branch_3_i ignored: no recapture, no count.
- PEND, mem_stall_i=0:
  - pc_o<=pend_pc; flush_o=1, stall_o=0.
  - hazard_stall_i ignored; no count. Go RUN.
- Latency: redirect is visible on pc_o the cycle after the stall-free flush cycle. Buffered redirect appears on pc_o the cycle after mem_stall_i falls.
- Counters hold at all-ones; no wrap.
- Simultaneous increments in one cycle are independent (one per counter).

Decomposition:
- Package fetch_ctrl_pkg:
  - state encoding localparams ST_RUN=1'b0, ST_PEND=1'b1.
  - default RESET_PC, CNT_W.
- Sub-module sat_counter:
  - parameter W; ports clk, rst, inc_i, cnt_o; holds at all-ones.
  - Instantiated twice.

Test Plan:
- Reset asserted mid-PEND with pend_pc=0x80 -> immediately pc_o=0, pend_o=0, counters 0; after release with next_pc_i=0x4, pc_o=0x4 next cycle.
- Sequential fetch, next_pc_i=0x10, all stalls 0 -> pc_o=0x10 next cycle; flush_o=0, stall_o=0.
- flush_i=1, next_pc_i=0x200, is_branch_3_i=1, no stall -> flush_o=1 same cycle; pc_o=0x200 next cycle; mispred_cnt=1, branch_cnt=1.
- flush_i=1, next_pc_i=0x300 during mem_stall_i=1; 4 stall cycles with next_pc_i changing to 0x999 -> pend_o=1, pc_o unchanged, counters +1 once; cycle mem_stall_i falls: flush_o=1; next cycle pc_o=0x300, pend_o=0.
- hazard_stall_i=1 with flush_i=1 -> flush wins: pc_o=target; with flush_i=0 -> pc_o holds, stall_o=1; next_pc_i=0x203 loads as 0x200.
- Counters preloaded via forced sequence to all-ones, another mispredict -> both counters stay all-ones.
